// File: rtl/uart_probe_loader.sv
// rtl/uart_probe_loader.sv - UART write packets (A5, addr, data) into 8 frame-synchronised probe channels
// Define UART_PROBE_PARITY_EN to receive 8E1 frames instead of 8N1.
module uart_probe_loader #(
  parameter int unsigned CLK_HZ       = 27000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned TIMEOUT_BITS = 32,
  parameter int unsigned SYNC_UPDATE  = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  input  logic       frame_start,
  output logic [7:0] out_0,
  output logic [7:0] out_1,
  output logic [7:0] out_2,
  output logic [7:0] out_3,
  output logic [7:0] out_4,
  output logic [7:0] out_5,
  output logic [7:0] out_6,
  output logic [7:0] out_7,
  output logic       pkt_ok,
  output logic       err,
  output logic       dirty
);

  localparam int unsigned CPB      = CLK_HZ / BAUD;
  localparam logic [31:0] BIT_END  = 32'(CPB - 1);
  localparam logic [31:0] HALF_END = 32'((CPB / 2) - 1);
  localparam logic [31:0] TO_END   = 32'((TIMEOUT_BITS * CPB) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PROBE_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } rx_state_e;

  typedef enum logic [1:0] {P_SYNC, P_ADDR, P_DATA} p_state_e;

  logic        sync1_q, rxs_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  bitn_q, bitn_d;
  logic [7:0]  shreg_q, shreg_d;
`ifdef UART_PROBE_PARITY_EN
  logic        par_q, par_d;
`endif
  p_state_e    p_state_q, p_state_d;
  logic [2:0]  addr_q, addr_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic [7:0]  shadow_q [8];
  logic [7:0]  shadow_d [8];
  logic [7:0]  out_q [8];
  logic [7:0]  out_d [8];
  logic        dirty_q, dirty_d;
  logic        pkt_ok_q, pkt_ok_d;
  logic        err_q, err_d;

  logic        bit_tick;
  logic        byte_valid;
  logic        rx_err;
  logic        write;

  assign bit_tick = (cnt_q == BIT_END);

  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bitn_d     = bitn_q;
    shreg_d    = shreg_q;
`ifdef UART_PROBE_PARITY_EN
    par_d      = par_q;
`endif
    byte_valid = 1'b0;
    rx_err     = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          rx_state_d = S_START;
          cnt_d      = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_END) begin
          cnt_d      = '0;
          bitn_d     = '0;
          rx_state_d = rxs_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          cnt_d   = '0;
          shreg_d = {rxs_q, shreg_q[7:1]};
          bitn_d  = bitn_q + 3'd1;
          if (bitn_q == 3'd7) begin
`ifdef UART_PROBE_PARITY_EN
            rx_state_d = S_PARITY;
`else
            rx_state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
`ifdef UART_PROBE_PARITY_EN
      S_PARITY: begin
        if (bit_tick) begin
          cnt_d      = '0;
          par_d      = rxs_q;
          rx_state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
`endif
      S_STOP: begin
        if (bit_tick) begin
          cnt_d = '0;
          // a framing error takes priority so a bad stop plus bad parity yields one err
          if (!rxs_q) begin
            rx_err     = 1'b1;
            rx_state_d = S_BREAK;
`ifdef UART_PROBE_PARITY_EN
          end else if (par_q != ^shreg_q) begin
            rx_err     = 1'b1;
            rx_state_d = S_IDLE;
`endif
          end else begin
            byte_valid = 1'b1;
            rx_state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_BREAK: begin
        if (rxs_q) rx_state_d = S_IDLE;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    p_state_d = p_state_q;
    addr_d    = addr_q;
    err_d     = rx_err;
    write     = 1'b0;
    to_cnt_d  = (p_state_q == P_SYNC) ? 32'd0 : to_cnt_q + 32'd1;
    if (rx_err) begin
      p_state_d = P_SYNC;
      to_cnt_d  = '0;
    end else if (byte_valid) begin
      to_cnt_d = '0;
      case (p_state_q)
        P_SYNC: if (shreg_q == 8'hA5) p_state_d = P_ADDR;
        P_ADDR: begin
          if (shreg_q[7:3] == 5'd0) begin
            addr_d    = shreg_q[2:0];
            p_state_d = P_DATA;
          end else if (shreg_q != 8'hA5) begin
            err_d     = 1'b1;
            p_state_d = P_SYNC;
          end
        end
        P_DATA: begin
          write     = 1'b1;
          p_state_d = P_SYNC;
        end
        default: p_state_d = P_SYNC;
      endcase
    end else if (p_state_q != P_SYNC && to_cnt_q == TO_END) begin
      p_state_d = P_SYNC;
      to_cnt_d  = '0;
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    out_d    = out_q;
    dirty_d  = dirty_q;
    pkt_ok_d = write;
    if (SYNC_UPDATE != 0) begin
      // commit reads the pre-write shadow; a same-cycle write stays pending
      if (frame_start) begin
        out_d   = shadow_q;
        dirty_d = 1'b0;
      end
      if (write) begin
        shadow_d[addr_q] = shreg_q;
        dirty_d          = 1'b1;
      end
    end else begin
      dirty_d = 1'b0;
      if (write) begin
        shadow_d[addr_q] = shreg_q;
        out_d[addr_q]    = shreg_q;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rx_state_q <= S_IDLE;
      cnt_q      <= '0;
      bitn_q     <= '0;
      shreg_q    <= '0;
`ifdef UART_PROBE_PARITY_EN
      par_q      <= 1'b0;
`endif
      p_state_q  <= P_SYNC;
      addr_q     <= '0;
      to_cnt_q   <= '0;
      shadow_q   <= '{default: 8'h00};
      out_q      <= '{default: 8'h00};
      dirty_q    <= 1'b0;
      pkt_ok_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= rx;
      rxs_q      <= sync1_q;
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bitn_q     <= bitn_d;
      shreg_q    <= shreg_d;
`ifdef UART_PROBE_PARITY_EN
      par_q      <= par_d;
`endif
      p_state_q  <= p_state_d;
      addr_q     <= addr_d;
      to_cnt_q   <= to_cnt_d;
      shadow_q   <= shadow_d;
      out_q      <= out_d;
      dirty_q    <= dirty_d;
      pkt_ok_q   <= pkt_ok_d;
      err_q      <= err_d;
    end
  end

  assign out_0  = out_q[0];
  assign out_1  = out_q[1];
  assign out_2  = out_q[2];
  assign out_3  = out_q[3];
  assign out_4  = out_q[4];
  assign out_5  = out_q[5];
  assign out_6  = out_q[6];
  assign out_7  = out_q[7];
  assign pkt_ok = pkt_ok_q;
  assign err    = err_q;
  assign dirty  = dirty_q;

endmodule

// File: tb/tb_uart_probe_loader.sv
// tb/tb_uart_probe_loader.sv - randomized bench for uart_probe_loader against a byte-level packet model
// Honours UART_PROBE_PARITY_EN when the design is built with it.
module tb_uart_probe_loader;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int CPB    = CLK_HZ / BAUD;
`ifdef UART_PROBE_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int STOP_CENTER = (NBITS - 1) * CPB + CPB / 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic rx = 1'b1;
  logic frame_start = 1'b0;
  wire [7:0] o1 [8];
  wire [7:0] o0 [8];
  wire pkt_ok1, err1, dirty1, pkt_ok0, err0, dirty0;

  always #5 clk = ~clk;

  uart_probe_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_BITS(32), .SYNC_UPDATE(1)) dut (
    .clk(clk), .resetn(resetn), .rx(rx), .frame_start(frame_start),
    .out_0(o1[0]), .out_1(o1[1]), .out_2(o1[2]), .out_3(o1[3]),
    .out_4(o1[4]), .out_5(o1[5]), .out_6(o1[6]), .out_7(o1[7]),
    .pkt_ok(pkt_ok1), .err(err1), .dirty(dirty1)
  );

  uart_probe_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_BITS(32), .SYNC_UPDATE(0)) dut0 (
    .clk(clk), .resetn(resetn), .rx(rx), .frame_start(frame_start),
    .out_0(o0[0]), .out_1(o0[1]), .out_2(o0[2]), .out_3(o0[3]),
    .out_4(o0[4]), .out_5(o0[5]), .out_6(o0[6]), .out_7(o0[7]),
    .pkt_ok(pkt_ok0), .err(err0), .dirty(dirty0)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int pkt1_cnt = 0, err1_cnt = 0, pkt0_cnt = 0, err0_cnt = 0;

  logic [7:0] m_shadow [8];
  logic [7:0] m_out1 [8];
  logic [7:0] m_out0 [8];
  logic       m_dirty;
  int         m_ps;
  logic [2:0] m_addr;
  int         exp_pkt = 0;
  int         exp_err = 0;
  int         lat = 0;

  always @(negedge clk) begin
    if (pkt_ok1) pkt1_cnt++;
    if (err1) err1_cnt++;
    if (pkt_ok0) pkt0_cnt++;
    if (err0) err0_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = 8'h00;
      m_out1[i]   = 8'h00;
      m_out0[i]   = 8'h00;
    end
    m_dirty = 1'b0;
    m_ps    = 0;
    m_addr  = 3'd0;
  endtask

  // Packet rules applied to one correctly framed byte
  task automatic m_byte(input logic [7:0] b);
    case (m_ps)
      0: if (b == 8'hA5) m_ps = 1;
      1: begin
        if (b[7:3] == 5'd0) begin
          m_addr = b[2:0];
          m_ps   = 2;
        end else if (b != 8'hA5) begin
          exp_err++;
          m_ps = 0;
        end
      end
      default: begin
        m_shadow[m_addr] = b;
        m_out0[m_addr]   = b;
        m_dirty          = 1'b1;
        exp_pkt++;
        m_ps = 0;
      end
    endcase
  endtask

  task automatic m_rx_err();
    exp_err++;
    m_ps = 0;
  endtask

  task automatic m_frame();
    for (int i = 0; i < 8; i++) m_out1[i] = m_shadow[i];
    m_dirty = 1'b0;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok, input int gap);
    @(posedge clk);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_PROBE_PARITY_EN
    drive_bit((^b) ^ !par_ok);
`endif
    drive_bit(stop_ok);
    rx = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  task automatic tx(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b1, $urandom_range(2, 30));
    m_byte(b);
  endtask

  task automatic pulse_frame();
    @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    m_frame();
  endtask

  task automatic idle_resync();
    repeat (400) @(posedge clk);
    m_ps = 0;
  endtask

  task automatic check_all(input string tag);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_out%0d", tag, i), o1[i], m_out1[i]);
      chk($sformatf("%s_direct_out%0d", tag, i), o0[i], m_out0[i]);
    end
    chk({tag, "_dirty"}, dirty1, m_dirty);
    chk({tag, "_direct_dirty"}, dirty0, 1'b0);
    chk({tag, "_pkt_ok_count"}, pkt1_cnt, exp_pkt);
    chk({tag, "_direct_pkt_ok_count"}, pkt0_cnt, exp_pkt);
    chk({tag, "_err_count"}, err1_cnt, exp_err);
    chk({tag, "_direct_err_count"}, err0_cnt, exp_err);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] o0_prev;
    int kind;
    logic [7:0] a, d;

    m_reset();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    check_all("reset");

    // A5 03 5A: measure write latency and check the direct instance updates with pkt_ok
    tx(8'hA5);
    send_frame(8'h03, 1'b1, 1'b1, 10);
    m_byte(8'h03);
    fork
      send_frame(8'h5A, 1'b1, 1'b1, 10);
      begin
        @(posedge clk);
        o0_prev = o0[3];
        for (int n = 1; n <= 200; n++) begin
          @(posedge clk);
          @(negedge clk);
          if (pkt_ok1) begin
            lat = n;
            chk("direct_out_with_pkt_ok", o0[3], 8'h5A);
            chk("direct_out_before_pkt_ok", o0_prev, 8'h00);
            break;
          end
          o0_prev = o0[3];
        end
      end
    join
    m_byte(8'h5A);
    chk("write_latency_window", (lat >= STOP_CENTER && lat <= STOP_CENTER + 6), 1);
    if (lat == 0) lat = STOP_CENTER + 3;
    check_all("t1_pending");
    pulse_frame();
    check_all("t1_commit");

    // resync on repeated A5, then an out-of-range address
    tx(8'hA5); tx(8'hA5); tx(8'h07); tx(8'hFF);
    pulse_frame();
    check_all("t2_resync");
    tx(8'hA5); tx(8'h08); tx(8'h11);
    check_all("t2_bad_addr");

    // start-bit glitch, then a framing error and recovery
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    check_all("t3_glitch");
    send_frame(8'h55, 1'b0, 1'b1, 20);
    m_rx_err();
    check_all("t3_framing");
    tx(8'hA5); tx(8'h00); tx(8'hC3);
    pulse_frame();
    check_all("t3_recover");

    // inter-byte timeout
    tx(8'hA5);
    send_frame(8'h02, 1'b1, 1'b1, 0);
    m_byte(8'h02);
    idle_resync();
    tx(8'h77);
    check_all("t4_timeout");

    // frame_start on the write edge commits the pre-write shadow
    tx(8'hA5); tx(8'h06); tx(8'h44);
    tx(8'hA5);
    send_frame(8'h01, 1'b1, 1'b1, 10);
    m_byte(8'h01);
    fork
      send_frame(8'h3C, 1'b1, 1'b1, 10);
      begin
        @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        #1 frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
      end
    join
    m_frame();
    m_byte(8'h3C);
    check_all("t5_same_cycle");
    pulse_frame();
    check_all("t5_next_frame");

    tx(8'hA5); tx(8'h04); tx(8'h81);
    check_all("t6_direct");
`ifdef UART_PROBE_PARITY_EN
    tx(8'hA5); tx(8'h04);
    send_frame(8'h7E, 1'b1, 1'b0, 20);
    m_rx_err();
    check_all("t6_parity");
    send_frame(8'h33, 1'b0, 1'b0, 20);
    m_rx_err();
    check_all("t6_parity_and_framing");
`endif

    // reset in the middle of a data byte
    tx(8'hA5); tx(8'h05);
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (35) @(posedge clk);
    #1 resetn = 1'b0;
    rx = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    check_all("t7_in_reset");
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (5) @(posedge clk);
    tx(8'hA5); tx(8'h05); tx(8'hE7);
    pulse_frame();
    check_all("t7_after_reset");

    // randomized packet stream
    for (int it = 0; it < 25; it++) begin
      kind = $urandom_range(0, 7);
      a = 8'($urandom_range(0, 7));
      d = 8'($urandom_range(0, 255));
      if (kind <= 4) begin
        tx(8'hA5); tx(a); tx(d);
      end else if (kind == 5) begin
        a = 8'($urandom_range(8, 255));
        if (a == 8'hA5) a = 8'h08;
        tx(8'hA5); tx(a); tx(d);
      end else if (kind == 6) begin
        tx(d);
      end else begin
        send_frame(d, 1'b0, $urandom_range(0, 1) == 1, 20);
        m_rx_err();
      end
      if ($urandom_range(0, 1) == 1) pulse_frame();
      check_all($sformatf("rand%0d", it));
    end
    idle_resync();
    pulse_frame();
    check_all("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
